// File: rtl/unpacker_pkg.sv
// rtl/unpacker_pkg.sv - shared constants and FSM state type for the activation unpacker
package unpacker_pkg;

   localparam int BYTES_PER_WORD = 16;
   localparam int MASKS_PER_WORD = 8;
   localparam int GROUP_WORDS    = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD_MASK,
      LD_MASK,
      CHECK,
      RD_ENC,
      LD_ENC,
      EMIT,
      DONE
   } state_t;

endpackage

// File: rtl/count_ones.sv
// rtl/count_ones.sv - combinational population count
module count_ones #(
   parameter int MEM_BW = 16
) (
   input  logic [MEM_BW-1:0]             data,
   output logic [$clog2(MEM_BW+1)-1:0]   ones
);

   always_comb begin
      ones = '0;
      for (int i = 0; i < MEM_BW; i++) begin
         ones = ones + {{($clog2(MEM_BW+1)-1){1'b0}}, data[i]};
      end
   end

endmodule

// File: rtl/mask_expander.sv
// rtl/mask_expander.sv - scatters packed nonzero bytes into a dense word under a 16-bit mask
module mask_expander
   import unpacker_pkg::*;
#(
   parameter int IO_DATA_WIDTH = 8,
   parameter int MEM_BW        = 128
) (
   input  logic [BYTES_PER_WORD-1:0] mask,
   input  logic [MEM_BW-1:0]         window,
   output logic [MEM_BW-1:0]         dense
);

   int k;

   // k tracks how many packed bytes earlier dense bytes have already taken
   always_comb begin
      dense = '0;
      k     = 0;
      for (int j = 0; j < BYTES_PER_WORD; j++) begin
         if (mask[BYTES_PER_WORD-1-j]) begin
            dense[MEM_BW-1-IO_DATA_WIDTH*j -: IO_DATA_WIDTH] =
               window[MEM_BW-1-IO_DATA_WIDTH*k -: IO_DATA_WIDTH];
            k = k + 1;
         end
      end
   end

endmodule

// File: rtl/unpacker.sv
// rtl/unpacker.sv - rebuilds dense activation words from mask + packed-byte memory format
module unpacker
   import unpacker_pkg::*;
#(
   parameter int IO_DATA_WIDTH    = 8,
   parameter int MEM_BW           = 128,
   parameter int ADDR_WIDTH_ACT   = 14,
   parameter int ADDR_WIDTH_MASKS = 11
) (
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic                        start_unpacker,
   input  logic                        clear_counters,
   output logic                        ready_unpacker,
   output logic                        read_masks_en,
   output logic [ADDR_WIDTH_MASKS-1:0] masks_addr,
   input  logic [MEM_BW-1:0]           masks_rdata,
   output logic                        read_act_en,
   output logic [ADDR_WIDTH_ACT-1:0]   act_addr,
   input  logic [MEM_BW-1:0]           act_rdata,
   output logic [MEM_BW-1:0]           decoded_out,
   output logic                        decoded_valid,
   input  logic                        decoded_ready,
   output logic [3:0]                  decoded_index
);

   localparam int BUF_BITS = 2 * MEM_BW;
   localparam int MASK_W   = BYTES_PER_WORD;

   state_t                      state, state_next;
   logic [ADDR_WIDTH_MASKS-1:0] mask_cnt;
   logic [ADDR_WIDTH_ACT-1:0]   enc_cnt;
   logic [BUF_BITS-1:0]         buf_q;
   logic [BUF_BITS-1:0]         buf_app;
   logic [5:0]                  fill;
   logic [MEM_BW-1:0]           masks_q;
   logic [3:0]                  index;
   logic [MEM_BW-1:0]           dout_q;
   logic [MEM_BW-1:0]           dense;
   logic [MEM_BW-1:0]           window;
   logic [MASK_W-1:0]           cur_mask;
   logic [4:0]                  ones;
   logic                        need_fetch;

   assign cur_mask   = masks_q[MEM_BW-1-MASK_W*int'(index[2:0]) -: MASK_W];
   assign need_fetch = fill < {1'b0, ones};

   // Slots at and beyond fill are always zero, so OR-ing in the shifted word appends it.
   assign buf_app = buf_q | ({act_rdata, {MEM_BW{1'b0}}} >> {fill, 3'b000});
   assign window  = (state == LD_ENC) ? buf_app[BUF_BITS-1 -: MEM_BW]
                                      : buf_q[BUF_BITS-1 -: MEM_BW];

   assign decoded_out   = dout_q;
   assign decoded_index = index;

   count_ones #(.MEM_BW(MASK_W)) u_count_ones (
      .data (cur_mask),
      .ones (ones)
   );

   mask_expander #(
      .IO_DATA_WIDTH (IO_DATA_WIDTH),
      .MEM_BW        (MEM_BW)
   ) u_mask_expander (
      .mask   (cur_mask),
      .window (window),
      .dense  (dense)
   );

   always_ff @(posedge clk) begin
      if (rst_in) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next     = state;
      read_masks_en  = 1'b0;
      masks_addr     = '0;
      read_act_en    = 1'b0;
      act_addr       = '0;
      decoded_valid  = 1'b0;
      ready_unpacker = 1'b0;
      case (state)
         IDLE:    if (start_unpacker) state_next = RD_MASK;
         RD_MASK: begin
            read_masks_en = 1'b1;
            masks_addr    = mask_cnt;
            state_next    = LD_MASK;
         end
         LD_MASK: state_next = CHECK;
         CHECK:   state_next = need_fetch ? RD_ENC : EMIT;
         RD_ENC: begin
            read_act_en = 1'b1;
            act_addr    = enc_cnt;
            state_next  = LD_ENC;
         end
         LD_ENC:  state_next = EMIT;
         EMIT: begin
            decoded_valid = 1'b1;
            if (decoded_ready) begin
               if (index == 4'(GROUP_WORDS-1))         state_next = DONE;
               else if (index == 4'(MASKS_PER_WORD-1)) state_next = RD_MASK;
               else                                    state_next = CHECK;
            end
         end
         DONE: begin
            ready_unpacker = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         mask_cnt <= '0;
         enc_cnt  <= '0;
         buf_q    <= '0;
         fill     <= '0;
         masks_q  <= '0;
         index    <= '0;
         dout_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_counters) begin
                  mask_cnt <= '0;
                  enc_cnt  <= '0;
               end
            end
            RD_MASK: mask_cnt <= mask_cnt + 1'b1;
            LD_MASK: masks_q  <= masks_rdata;
            CHECK:   if (!need_fetch) dout_q <= dense;
            RD_ENC:  enc_cnt  <= enc_cnt + 1'b1;
            LD_ENC: begin
               buf_q  <= buf_app;
               fill   <= fill + 6'd16;
               dout_q <= dense;
            end
            EMIT: begin
               if (decoded_ready) begin
                  buf_q  <= buf_q << {ones, 3'b000};
                  fill   <= fill - {1'b0, ones};
                  index  <= index + 1'b1;
                  dout_q <= '0;
               end
            end
            DONE: begin
               buf_q <= '0;
               fill  <= '0;
               index <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unpacker.sv
// tb/tb_unpacker.sv - self-checking bench for unpacker against a byte-stream reference model
module tb_unpacker;

   logic         clk = 1'b0;
   logic         rst_in;
   logic         start_unpacker;
   logic         clear_counters;
   logic         ready_unpacker;
   logic         read_masks_en;
   logic [10:0]  masks_addr;
   logic [127:0] masks_rdata;
   logic         read_act_en;
   logic [13:0]  act_addr;
   logic [127:0] act_rdata;
   logic [127:0] decoded_out;
   logic         decoded_valid;
   logic         decoded_ready;
   logic [3:0]   decoded_index;

   always #5 clk = ~clk;

   unpacker dut (
      .clk            (clk),
      .rst_in         (rst_in),
      .start_unpacker (start_unpacker),
      .clear_counters (clear_counters),
      .ready_unpacker (ready_unpacker),
      .read_masks_en  (read_masks_en),
      .masks_addr     (masks_addr),
      .masks_rdata    (masks_rdata),
      .read_act_en    (read_act_en),
      .act_addr       (act_addr),
      .act_rdata      (act_rdata),
      .decoded_out    (decoded_out),
      .decoded_valid  (decoded_valid),
      .decoded_ready  (decoded_ready),
      .decoded_index  (decoded_index)
   );

   logic [127:0] mask_mem [0:2047];
   logic [127:0] act_mem  [0:16383];

   always @(posedge clk) begin
      if (read_masks_en) masks_rdata <= mask_mem[masks_addr];
      else               masks_rdata <= {$urandom, $urandom, $urandom, $urandom};
      if (read_act_en)   act_rdata   <= act_mem[act_addr];
      else               act_rdata   <= {$urandom, $urandom, $urandom, $urandom};
   end

   int total = 0;
   int bad   = 0;
   int mask_base = 0;
   int enc_base  = 0;
   logic [15:0]  grp_masks [16];
   logic [127:0] exp_words [16];

   typedef struct {
      int           kind;
      logic [15:0]  ma;
      logic [15:0]  mb;
      int           bytemode;
      int           ready_mode;
      bit           bp;
      int           exp_reads;
      int           exp_lat;
      int           exp_gap;
      bit           hand_en;
      logic [127:0] hand_w0;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " ctl"}, {95'd0, ready_unpacker, read_masks_en, masks_addr, read_act_en,
                            act_addr, decoded_valid, decoded_index}, 128'd0);
      check({name, " data"}, decoded_out, 128'd0);
   endtask

   // Model: the encoded memory is one byte stream; each mask bit in order takes the next byte.
   task automatic build_group(input int kind, input logic [15:0] ma, input logic [15:0] mb,
                              input int bytemode, output int reads);
      logic [7:0]   stream [256];
      logic [127:0] mw [2];
      logic [127:0] aw;
      int           total_ones;
      int           ptr;
      total_ones = 0;
      mw[0] = '0;
      mw[1] = '0;
      for (int w = 0; w < 16; w++) begin
         if (kind == 0) grp_masks[w] = (w % 2 == 0) ? ma : mb;
         else           grp_masks[w] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         total_ones += $countones(grp_masks[w]);
         mw[w/8][127-16*(w%8) -: 16] = grp_masks[w];
      end
      mask_mem[mask_base % 2048]       = mw[0];
      mask_mem[(mask_base + 1) % 2048] = mw[1];
      for (int n = 0; n < total_ones; n++) begin
         if (bytemode == 1)      stream[n] = 8'((n % 16) + 1);
         else if (bytemode == 2) stream[n] = 8'(17 * ((n % 15) + 1));
         else                    stream[n] = 8'($urandom_range(1, 255));
      end
      reads = (total_ones + 15) / 16;
      for (int r = 0; r < reads; r++) begin
         aw = '0;
         for (int b = 0; b < 16; b++)
            if (16*r + b < total_ones) aw[127-8*b -: 8] = stream[16*r + b];
         act_mem[(enc_base + r) % 16384] = aw;
      end
      ptr = 0;
      for (int w = 0; w < 16; w++) begin
         exp_words[w] = '0;
         for (int j = 0; j < 16; j++) begin
            if (grp_masks[w][15-j]) begin
               exp_words[w][127-8*j -: 8] = stream[ptr];
               ptr++;
            end
         end
      end
   endtask

   task automatic run_group(input string tag, input int ready_mode, input bit bp, input bit clr,
                            input int exp_reads, input int exp_lat, input int exp_gap,
                            input bit hand_en, input logic [127:0] hand_w0);
      logic [127:0] got_w [$];
      int           got_i [$];
      logic [127:0] bp_save;
      int mreads, areads, maddr_bad, aaddr_bad, pulses, post;
      int first_valid, hs0, hs1, bp_cnt, bp_bad;
      bit bp_done, finished;
      mreads = 0; areads = 0; maddr_bad = 0; aaddr_bad = 0; pulses = 0; post = 0;
      first_valid = -1; hs0 = -1; hs1 = -1; bp_cnt = 0; bp_bad = 0;
      bp_done = 0; finished = 0; bp_save = '0;
      @(negedge clk);
      start_unpacker = 1'b1;
      clear_counters = clr;
      decoded_ready  = (ready_mode == 1);
      for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
         @(negedge clk);
         start_unpacker = 1'b0;
         clear_counters = 1'b0;
         if (read_masks_en) begin
            if (masks_addr != 11'((mask_base + mreads) % 2048)) maddr_bad++;
            mreads++;
         end
         if (read_act_en) begin
            if (act_addr != 14'((enc_base + areads) % 16384)) aaddr_bad++;
            areads++;
         end
         if (ready_unpacker) pulses++;
         if (pulses > 0) begin
            post++;
            if (post > 3) finished = 1;
         end
         if (decoded_valid && first_valid < 0) first_valid = cyc;
         if (ready_mode == 1) decoded_ready = 1'b1;
         else                 decoded_ready = ($urandom_range(0, 2) != 0);
         if (bp && !bp_done && decoded_valid && decoded_index == 4'd3) begin
            if (bp_cnt == 0) bp_save = decoded_out;
            else if (decoded_out !== bp_save || read_act_en || read_masks_en) bp_bad++;
            bp_cnt++;
            decoded_ready = 1'b0;
            if (bp_cnt == 5) bp_done = 1;
         end
         if (decoded_valid && decoded_ready) begin
            got_w.push_back(decoded_out);
            got_i.push_back(int'(decoded_index));
            if (hs0 < 0)      hs0 = cyc;
            else if (hs1 < 0) hs1 = cyc;
         end
      end
      decoded_ready = 1'b0;
      check($sformatf("%s completed", tag), 128'(finished), 128'd1);
      check($sformatf("%s ready pulses", tag), 128'(pulses), 128'd1);
      check($sformatf("%s word count", tag), 128'(got_w.size()), 128'd16);
      for (int w = 0; w < 16; w++) begin
         if (w < got_w.size()) begin
            check($sformatf("%s word%0d", tag, w), got_w[w], exp_words[w]);
            check($sformatf("%s index%0d", tag, w), 128'(got_i[w]), 128'(w));
         end
      end
      if (hand_en && got_w.size() > 0) check($sformatf("%s hand word0", tag), got_w[0], hand_w0);
      check($sformatf("%s mask reads", tag), 128'(mreads), 128'd2);
      check($sformatf("%s mask addr errors", tag), 128'(maddr_bad), 128'd0);
      check($sformatf("%s enc reads", tag), 128'(areads), 128'(exp_reads));
      check($sformatf("%s enc addr errors", tag), 128'(aaddr_bad), 128'd0);
      if (exp_lat > 0) check($sformatf("%s first latency", tag), 128'(first_valid), 128'(exp_lat));
      if (exp_gap > 0) check($sformatf("%s word gap", tag), 128'(hs1 - hs0), 128'(exp_gap));
      if (bp) begin
         check($sformatf("%s backpressure held", tag), 128'(bp_done), 128'd1);
         check($sformatf("%s backpressure stable", tag), 128'(bp_bad), 128'd0);
      end
      mask_base = (mask_base + 2) % 2048;
      enc_base  = (enc_base + exp_reads) % 16384;
   endtask

   initial begin
      int reads;
      int found;
      int spurious;

      vecs[0] = '{0, 16'hFFFF, 16'hFFFF, 1, 1, 1'b0, 16, 6, 4, 1'b1,
                  128'h0102030405060708090A0B0C0D0E0F10};
      vecs[1] = '{0, 16'hA000, 16'hA000, 2, 1, 1'b0, 2, 6, 2, 1'b1,
                  128'h11002200000000000000000000000000};
      vecs[2] = '{0, 16'h0000, 16'h0000, 0, 1, 1'b0, 0, 4, 2, 1'b1, 128'd0};
      vecs[3] = '{0, 16'hFFF0, 16'h00FF, 0, 2, 1'b0, 10, 0, 0, 1'b0, 128'd0};
      vecs[4] = '{1, 16'h0, 16'h0, 0, 2, 1'b1, -1, 0, 0, 1'b0, 128'd0};
      vecs[5] = '{1, 16'h0, 16'h0, 0, 2, 1'b0, -1, 0, 0, 1'b0, 128'd0};
      vecs[6] = '{0, 16'hFFF0, 16'h00FF, 0, 1, 1'b1, 10, 6, 4, 1'b0, 128'd0};
      vecs[7] = '{1, 16'h0, 16'h0, 0, 2, 1'b0, -1, 0, 0, 1'b0, 128'd0};

      rst_in = 1'b1;
      start_unpacker = 1'b0;
      clear_counters = 1'b0;
      decoded_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_in = 1'b0;
      @(negedge clk);
      check_outputs_zero("idle after reset");

      for (int i = 0; i < 8; i++) begin
         build_group(vecs[i].kind, vecs[i].ma, vecs[i].mb, vecs[i].bytemode, reads);
         if (vecs[i].exp_reads < 0) vecs[i].exp_reads = reads;
         run_group($sformatf("vec%0d", i), vecs[i].ready_mode, vecs[i].bp, 1'b0,
                   vecs[i].exp_reads, vecs[i].exp_lat, vecs[i].exp_gap,
                   vecs[i].hand_en, vecs[i].hand_w0);
      end

      // clear together with start: the group must fetch from address 0 on both memories
      mask_base = 0;
      enc_base  = 0;
      build_group(1, 16'h0, 16'h0, 0, reads);
      run_group("clear+start", 2, 1'b0, 1'b1, reads, 0, 0, 1'b0, 128'd0);

      build_group(1, 16'h0, 16'h0, 0, reads);
      found = 0;
      @(negedge clk);
      start_unpacker = 1'b1;
      decoded_ready  = 1'b1;
      for (int cyc = 0; cyc < 500 && found == 0; cyc++) begin
         @(negedge clk);
         start_unpacker = 1'b0;
         if (decoded_valid && decoded_index == 4'd5) found = 1;
      end
      check("reached index 5", 128'(found), 128'd1);
      rst_in = 1'b1;
      @(negedge clk);
      check_outputs_zero("mid-group reset");
      rst_in = 1'b0;
      decoded_ready = 1'b0;
      spurious = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (ready_unpacker || decoded_valid || read_masks_en || read_act_en) spurious++;
      end
      check("no activity after reset", 128'(spurious), 128'd0);

      mask_base = 0;
      enc_base  = 0;
      build_group(1, 16'h0, 16'h0, 0, reads);
      run_group("after reset", 2, 1'b0, 1'b0, reads, 0, 0, 1'b0, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
